led_pattern_gen: RTL and testbench

Parametrised multi-channel LED pattern generator for the FPGA fabric. It generalises the single fixed 1 Hz heartbeat to NUM_CH channels. Each channel is independently set to OFF, ON, BLINK (programmable period and duty) or PULSE (one-shot) through a single-cycle config write port. The block sits between the HPS-facing control logic and the board LED/GPIO pins, and shares one millisecond time base across all channels.

---
 rtl/led_pattern_pkg.sv | 29 ++
 rtl/led_pattern_channel.sv | 114 +++++++++++
 rtl/led_pattern_gen.sv | 74 +++++++
 tb/tb_led_pattern_gen.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_pkg.sv
// Shared types, reset constants and the on-time helper for the LED pattern generator.
package led_pattern_pkg;

   // Channel operating mode, encoded as written on cfg_mode
   typedef enum logic [1:0] {
      LED_OFF   = 2'd0,
      LED_ON    = 2'd1,
      LED_BLINK = 2'd2,
      LED_PULSE = 2'd3
   } led_mode_e;

   // Heartbeat defaults for channel 0 (1 s period, 50 % on)
   localparam int HB_PERIOD = 1000;
   localparam int HB_ON     = 500;

   // Widest period the helper handles; callers zero-extend and truncate back
   localparam int MAX_PERIOD_W = 16;

   // on_time = (period * duty) >> 8, duty in 1/256 units
   function automatic logic [MAX_PERIOD_W-1:0] calc_on_time(
      input logic [MAX_PERIOD_W-1:0] period,
      input logic [7:0]              duty
   );
      logic [MAX_PERIOD_W+7:0] product_s;
      product_s = {8'd0, period} * {{MAX_PERIOD_W{1'b0}}, duty};
      return product_s[MAX_PERIOD_W+7:8];
   endfunction

endpackage

// File: rtl/led_pattern_channel.sv
// One LED channel: config registers, ms counter, mode sequencing and registered outputs.
module led_pattern_channel
   import led_pattern_pkg::*;
#(
   parameter int PERIOD_W = 12,
   parameter bit RESET_HB = 1'b0
) (
   input  logic                fpga_clk_50,
   input  logic                hps_fpga_reset_n,
   input  logic                wr_en,
   input  logic [1:0]          cfg_mode,
   input  logic [PERIOD_W-1:0] cfg_period,
   input  logic [7:0]          cfg_duty,
   input  logic                tick_ms,
   input  logic                sync_restart,
   output logic                led,
   output logic                pulse_done
);

   localparam logic [PERIOD_W-1:0] ZERO       = {PERIOD_W{1'b0}};
   localparam logic [PERIOD_W-1:0] ONE        = PERIOD_W'(1);
   localparam led_mode_e           RST_MODE   = RESET_HB ? LED_BLINK : LED_OFF;
   localparam logic [PERIOD_W-1:0] RST_PERIOD = RESET_HB ? PERIOD_W'(HB_PERIOD) : ZERO;
   localparam logic [PERIOD_W-1:0] RST_ON     = RESET_HB ? PERIOD_W'(HB_ON) : ZERO;

   led_mode_e           mode_r,    mode_s;
   logic [PERIOD_W-1:0] period_r,  period_s;
   logic [PERIOD_W-1:0] on_time_r, on_time_s;
   logic [PERIOD_W-1:0] cnt_r,     cnt_s;
   logic                led_r,     led_s;
   logic                done_r,    done_s;
   logic [PERIOD_W-1:0] on_time_wr_s;
   logic                cnt_last_s;
   led_mode_e           cfg_mode_s;

   assign cfg_mode_s   = led_mode_e'(cfg_mode);
   assign on_time_wr_s = PERIOD_W'(calc_on_time(MAX_PERIOD_W'(cfg_period), cfg_duty));
   // Period 0 counts as "always at the last step" so the counter never leaves 0
   assign cnt_last_s   = (period_r == ZERO) || (cnt_r == (period_r - ONE));

   // Next-state: write beats restart beats tick; level derived from the next state
   always_comb begin
      mode_s    = mode_r;
      period_s  = period_r;
      on_time_s = on_time_r;
      cnt_s     = cnt_r;
      done_s    = 1'b0;
      led_s     = 1'b0;
      if (wr_en) begin
         period_s  = cfg_period;
         on_time_s = on_time_wr_s;
         cnt_s     = ZERO;
         if ((cfg_mode_s == LED_PULSE) && (cfg_period == ZERO)) begin
            // zero-length pulse completes at once and never lights the LED
            mode_s = LED_OFF;
            done_s = 1'b1;
         end else begin
            mode_s = cfg_mode_s;
         end
      end else if (sync_restart) begin
         cnt_s = ZERO;
      end else if (tick_ms) begin
         case (mode_r)
            LED_BLINK: begin
               cnt_s = cnt_last_s ? ZERO : (cnt_r + ONE);
            end
            LED_PULSE: begin
               if (cnt_last_s) begin
                  mode_s = LED_OFF;
                  cnt_s  = ZERO;
                  done_s = 1'b1;
               end else begin
                  cnt_s = cnt_r + ONE;
               end
            end
            default: begin
               cnt_s = ZERO;
            end
         endcase
      end else begin
         cnt_s = cnt_r;
      end

      case (mode_s)
         LED_ON:    led_s = 1'b1;
         LED_BLINK: led_s = (cnt_s < on_time_s);
         LED_PULSE: led_s = 1'b1;
         default:   led_s = 1'b0;
      endcase
   end

   // State and output registers
   always_ff @(posedge fpga_clk_50 or negedge hps_fpga_reset_n) begin
      if (!hps_fpga_reset_n) begin
         mode_r    <= RST_MODE;
         period_r  <= RST_PERIOD;
         on_time_r <= RST_ON;
         cnt_r     <= ZERO;
         led_r     <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         mode_r    <= mode_s;
         period_r  <= period_s;
         on_time_r <= on_time_s;
         cnt_r     <= cnt_s;
         led_r     <= led_s;
         done_r    <= done_s;
      end
   end

   assign led        = led_r;
   assign pulse_done = done_r;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator sharing one 1 ms time base.
module led_pattern_gen
   import led_pattern_pkg::*;
#(
   parameter int NUM_CH          = 8,
   parameter int PRESCALE        = 50000,
   parameter int PERIOD_W        = 12,
   parameter bit RESET_HEARTBEAT = 1'b1,
   localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                fpga_clk_50,
   input  logic                hps_fpga_reset_n,
   input  logic                cfg_wr,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [1:0]          cfg_mode,
   input  logic [PERIOD_W-1:0] cfg_period,
   input  logic [7:0]          cfg_duty,
   input  logic                sync_restart,
   output logic [NUM_CH-1:0]   led_out,
   output logic [NUM_CH-1:0]   pulse_done,
   output logic                tick_ms
);

   localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);

   logic [PRESC_W-1:0] presc_r;
   logic               tick_ms_r;
   logic               presc_last_s;

   assign presc_last_s = (presc_r == PRESC_LAST);

   // Millisecond prescaler; restart zeroes it and swallows that cycle's tick
   always_ff @(posedge fpga_clk_50 or negedge hps_fpga_reset_n) begin
      if (!hps_fpga_reset_n) begin
         presc_r   <= {PRESC_W{1'b0}};
         tick_ms_r <= 1'b0;
      end else if (sync_restart) begin
         presc_r   <= {PRESC_W{1'b0}};
         tick_ms_r <= 1'b0;
      end else if (presc_last_s) begin
         presc_r   <= {PRESC_W{1'b0}};
         tick_ms_r <= 1'b1;
      end else begin
         presc_r   <= presc_r + PRESC_W'(1);
         tick_ms_r <= 1'b0;
      end
   end

   assign tick_ms = tick_ms_r;

   // Out-of-range cfg_ch values match no channel, so such writes are dropped
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic wr_en_s;
      assign wr_en_s = cfg_wr && (cfg_ch == CH_W'(i));

      led_pattern_channel #(
         .PERIOD_W (PERIOD_W),
         .RESET_HB (RESET_HEARTBEAT && (i == 0))
      ) u_ch (
         .fpga_clk_50      (fpga_clk_50),
         .hps_fpga_reset_n (hps_fpga_reset_n),
         .wr_en            (wr_en_s),
         .cfg_mode         (cfg_mode),
         .cfg_period       (cfg_period),
         .cfg_duty         (cfg_duty),
         .tick_ms          (tick_ms_r),
         .sync_restart     (sync_restart),
         .led              (led_out[i]),
         .pulse_done       (pulse_done[i])
      );
   end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen against a tick-counting reference model.
module tb_led_pattern_gen;

   localparam int NUM_CH   = 6;
   localparam int PRESCALE = 10;
   localparam int PERIOD_W = 12;
   localparam int CH_W     = 3;

   logic                fpga_clk_50 = 1'b0;
   logic                hps_fpga_reset_n;
   logic                cfg_wr;
   logic [CH_W-1:0]     cfg_ch;
   logic [1:0]          cfg_mode;
   logic [PERIOD_W-1:0] cfg_period;
   logic [7:0]          cfg_duty;
   logic                sync_restart;
   logic [NUM_CH-1:0]   led_out;
   logic [NUM_CH-1:0]   pulse_done;
   logic                tick_ms;

   led_pattern_gen #(
      .NUM_CH          (NUM_CH),
      .PRESCALE        (PRESCALE),
      .PERIOD_W        (PERIOD_W),
      .RESET_HEARTBEAT (1'b1)
   ) dut (
      .fpga_clk_50      (fpga_clk_50),
      .hps_fpga_reset_n (hps_fpga_reset_n),
      .cfg_wr           (cfg_wr),
      .cfg_ch           (cfg_ch),
      .cfg_mode         (cfg_mode),
      .cfg_period       (cfg_period),
      .cfg_duty         (cfg_duty),
      .sync_restart     (sync_restart),
      .led_out          (led_out),
      .pulse_done       (pulse_done),
      .tick_ms          (tick_ms)
   );

   always #10 fpga_clk_50 = ~fpga_clk_50;

   int checks = 0;
   int passed = 0;
   int done5_seen = 0;

   // Reference model: ticks elapsed since each channel was (re)configured
   int                m_mode   [NUM_CH];
   int                m_period [NUM_CH];
   int                m_on     [NUM_CH];
   int                m_ticks  [NUM_CH];
   logic [NUM_CH-1:0] m_led;
   logic [NUM_CH-1:0] m_done;
   logic              m_tick;
   int                m_edges;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_mode[c]   = 0;
         m_period[c] = 0;
         m_on[c]     = 0;
         m_ticks[c]  = 0;
      end
      m_mode[0]   = 2;
      m_period[0] = 1000;
      m_on[0]     = 500;
      m_led       = '0;
      m_done      = '0;
      m_tick      = 1'b0;
      m_edges     = 0;
   endtask

   task automatic model_edge();
      logic tick_prev;
      tick_prev = m_tick;
      for (int c = 0; c < NUM_CH; c++) begin
         m_done[c] = 1'b0;
         if (cfg_wr && (int'(cfg_ch) == c)) begin
            m_mode[c]   = int'(cfg_mode);
            m_period[c] = int'(cfg_period);
            m_on[c]     = (int'(cfg_period) * int'(cfg_duty)) / 256;
            m_ticks[c]  = 0;
         end else if (sync_restart) begin
            m_ticks[c] = 0;
         end else if (tick_prev && (m_mode[c] >= 2)) begin
            m_ticks[c]++;
         end
         if ((m_mode[c] == 3) && (m_ticks[c] >= m_period[c])) begin
            m_mode[c]  = 0;
            m_ticks[c] = 0;
            m_done[c]  = 1'b1;
         end
         case (m_mode[c])
            1:       m_led[c] = 1'b1;
            2:       m_led[c] = (m_period[c] != 0) && ((m_ticks[c] % m_period[c]) < m_on[c]);
            3:       m_led[c] = 1'b1;
            default: m_led[c] = 1'b0;
         endcase
      end
      if (sync_restart) m_edges = 0;
      else              m_edges++;
      m_tick = (m_edges > 0) && ((m_edges % PRESCALE) == 0);
   endtask

   task automatic cycle();
      @(posedge fpga_clk_50);
      model_edge();
      @(negedge fpga_clk_50);
      chk("led_out", 16'(led_out), 16'(m_led));
      chk("pulse_done", 16'(pulse_done), 16'(m_done));
      chk("tick_ms", 16'(tick_ms), 16'(m_tick));
      done5_seen += int'(pulse_done[5]);
      cfg_wr       = 1'b0;
      sync_restart = 1'b0;
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic write(input int ch, input int mode, input int period, input int duty);
      cfg_wr     = 1'b1;
      cfg_ch     = CH_W'(ch);
      cfg_mode   = 2'(mode);
      cfg_period = PERIOD_W'(period);
      cfg_duty   = 8'(duty);
      cycle();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_led"}, 16'(led_out), 16'h0000);
      chk({tag, "_done"}, 16'(pulse_done), 16'h0000);
      chk({tag, "_tick"}, 16'(tick_ms), 16'h0000);
   endtask

   initial begin
      hps_fpga_reset_n = 1'b0;
      cfg_wr           = 1'b0;
      cfg_ch           = '0;
      cfg_mode         = 2'd0;
      cfg_period       = '0;
      cfg_duty         = 8'd0;
      sync_restart     = 1'b0;
      model_reset();

      // 1: reset values, heartbeat on ch0
      repeat (3) @(negedge fpga_clk_50);
      check_reset_outputs("reset");
      hps_fpga_reset_n = 1'b1;
      cycle();
      chk("hb_first", 16'(led_out), 16'h0001);
      run(10020);

      // 2: ch3 BLINK period 8 duty 64 -> 2 ticks on, 6 off
      write(3, 2, 8, 64);
      run(200);

      // 3: ch5 PULSE 4 ticks, then a pulse rewritten mid-flight
      done5_seen = 0;
      write(5, 3, 4, 0);
      run(60);
      chk("pulse_once", 16'(done5_seen), 16'd1);
      done5_seen = 0;
      write(5, 3, 4, 0);
      run(25);
      write(5, 3, 4, 0);
      run(80);
      chk("pulse_rewrite_once", 16'(done5_seen), 16'd1);
      write(5, 3, 0, 0);
      run(5);

      // 4: write landing on a tick, then out-of-range writes
      for (int k = 0; k < 20; k++) begin
         if (tick_ms) break;
         cycle();
      end
      chk("tick_wait", 16'(tick_ms), 16'h0001);
      write(2, 2, 5, 128);
      run(60);
      write(6, 1, 5, 255);
      write(7, 3, 0, 0);
      run(40);

      // 5: two blinkers out of phase, realigned by sync_restart
      write(1, 2, 10, 128);
      run(30);
      write(2, 2, 10, 128);
      run(47);
      sync_restart = 1'b1;
      cycle();
      run(200);
      sync_restart = 1'b1;
      cfg_wr       = 1'b1;
      cfg_ch       = 3'd4;
      cfg_mode     = 2'd2;
      cfg_period   = 12'd7;
      cfg_duty     = 8'd200;
      cycle();
      run(150);

      // 6: reset in the middle of a pulse and a blink
      write(5, 3, 20, 0);
      write(4, 2, 6, 128);
      run(35);
      #3 hps_fpga_reset_n = 1'b0;
      #1 check_reset_outputs("async_rst");
      model_reset();
      repeat (2) begin
         @(negedge fpga_clk_50);
         check_reset_outputs("held_rst");
      end
      hps_fpga_reset_n = 1'b1;
      run(300);

      // Randomized traffic
      for (int k = 0; k < 2000; k++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 8) begin
            cfg_wr     = 1'b1;
            cfg_ch     = CH_W'($urandom_range(0, 7));
            cfg_mode   = 2'($urandom_range(0, 3));
            cfg_period = PERIOD_W'($urandom_range(0, 12));
            cfg_duty   = 8'($urandom_range(0, 255));
         end
         if ((r == 5) || (r >= 97)) sync_restart = 1'b1;
         cycle();
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
